// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: walks an external 1-bit ALU slice over WIDTH bits, LSB first.
// Optional flag outputs (zero, cout, overflow) are built when ALU_SERIAL_FLAGS_EN is defined.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             slc_src1,
  output logic             slc_src2,
  output logic             slc_A_invert,
  output logic             slc_B_invert,
  output logic             slc_cin,
  output logic             slc_less,
  output logic [1:0]       slc_operation,
  input  logic             slc_result,
  input  logic             slc_set,
  input  logic             slc_overflow,
  input  logic             slc_less_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef ALU_SERIAL_FLAGS_EN
  ,
  output logic             zero,
  output logic             cout,
  output logic             overflow
`endif
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [1:0] OP_SET = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] src1_q, src1_d;
  logic [WIDTH-1:0] src2_q, src2_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic accept;
  logic running;
  logic last_bit;
  logic set_last;

  assign accept   = (state_q == IDLE) && in_valid;
  assign running  = (state_q == RUN);
  assign last_bit = (idx_q == IW'(WIDTH - 1));
  assign set_last = running && last_bit && (ctrl_q[1:0] == OP_SET);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: slice drive is gated to zero outside RUN
  always_comb begin
    in_ready      = (state_q == IDLE);
    out_valid     = (state_q == DONE);
    slc_src1      = 1'b0;
    slc_src2      = 1'b0;
    slc_A_invert  = 1'b0;
    slc_B_invert  = 1'b0;
    slc_cin       = 1'b0;
    slc_less      = 1'b0;
    slc_operation = 2'b00;
    if (running) begin
      slc_src1      = src1_q[idx_q];
      slc_src2      = src2_q[idx_q];
      slc_A_invert  = ctrl_q[3];
      slc_B_invert  = ctrl_q[2];
      slc_cin       = carry_q;
      slc_operation = ctrl_q[1:0];
    end
  end

  // Datapath next values; carry is seeded from B_invert so subtraction gets its +1
  always_comb begin
    src1_d  = src1_q;
    src2_d  = src2_q;
    ctrl_d  = ctrl_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    if (accept) begin
      src1_d  = src1;
      src2_d  = src2;
      ctrl_d  = ALU_control;
      idx_d   = '0;
      carry_d = ALU_control[2];
    end else if (running) begin
      idx_d   = idx_q + IW'(1);
      carry_d = slc_set;
    end
  end

  // Per-bit result update; SET overwrites the whole word on the final bit
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_result
    if (gi == 0) begin : g_lsb
      assign result_d[gi] = set_last ? (slc_less_out ^ slc_overflow)
                          : (running && idx_q == IW'(gi)) ? slc_result
                          : result_q[gi];
    end else begin : g_upper
      assign result_d[gi] = set_last ? 1'b0
                          : (running && idx_q == IW'(gi)) ? slc_result
                          : result_q[gi];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src1_q   <= '0;
      src2_q   <= '0;
      ctrl_q   <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
    end else begin
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      ctrl_q   <= ctrl_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

`ifdef ALU_SERIAL_FLAGS_EN
  logic zero_q, zero_d;
  logic cout_q, cout_d;
  logic overflow_q, overflow_d;

  // Flags are captured together with the final result bit
  always_comb begin
    zero_d     = zero_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    if (running && last_bit) begin
      zero_d     = (result_d == '0);
      cout_d     = slc_set;
      overflow_d = ctrl_q[1] ? slc_overflow : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      zero_q     <= zero_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign zero     = zero_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;
`endif

endmodule

// File: doc/alu_serial_seq.md
ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid & in_ready.
REQ-006 SHALL have ports src1, src2  input  WIDTH  operands.
REQ-007 SHALL have port ALU_control  input  4  [3]=A_invert, [2]=B_invert, [1:0]=operation (00 AND, 01 OR, 10 ADD, 11 SET).
REQ-008 SHALL have ports slc_src1, slc_src2, slc_A_invert, slc_B_invert, slc_cin, slc_less  output  1 each  drive the 1-bit slice.
REQ-009 SHALL have port slc_operation  output  2  slice operation.
REQ-010 SHALL have ports slc_result, slc_set, slc_overflow, slc_less_out  input  1 each  slice result, carry-out, overflow, sum.
REQ-011 SHALL have ports out_valid  output  1, out_ready  input  1, result  output  WIDTH.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; in_ready=1 only in IDLE.
REQ-013 On accept SHALL latch src1, src2, ALU_control, clear bit index to 0, set carry register to ALU_control[2], enter RUN.
REQ-014 In RUN, bit index i SHALL drive slc_src1=src1[i], slc_src2=src2[i], slc_A_invert/B_invert/operation from latched control, slc_cin=carry register, slc_less=0.
REQ-015 Each RUN cycle SHALL store slc_result into result[i] and load slc_set into carry register.
REQ-016 RUN SHALL last exactly WIDTH cycles; after i=WIDTH-1 the FSM SHALL enter DONE; accept-to-out_valid latency = WIDTH+1 cycles.
REQ-017 For operation SET, on i=WIDTH-1 the block SHALL write result[0]=slc_less_out XOR slc_overflow and result[WIDTH-1:1]=0.
REQ-018 In DONE, out_valid=1 and result SHALL hold stable until out_valid & out_ready, then return to IDLE.
REQ-019 in_valid during RUN or DONE SHALL be ignored (no accept, no latch change).
REQ-020 Outside RUN all slc_* outputs SHALL be 0.
REQ-021 Back-to-back: out_ready=1 on first DONE cycle SHALL return to IDLE next cycle; next accept earliest that IDLE cycle.
REQ-022 Carry SHALL not propagate between operations; each op restarts from REQ-013.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, in_ready=1, out_valid=0, result=0, carry=0, index=0, all slc_*=0, regardless of state.
REQ-024 rst asserted mid-RUN or in DONE SHALL abort the operation with no out_valid pulse; rst SHALL dominate in_valid in the same cycle.

Configuration
REQ-025 Macro ALU_SERIAL_FLAGS_EN defined: SHALL add outputs zero, cout, overflow (1 bit each), valid with out_valid; zero=(result==0), cout=carry after bit WIDTH-1, overflow=slc_overflow at bit WIDTH-1 for ADD/SET else 0; all reset to 0.
REQ-026 Macro undefined: SHALL omit those ports and their registers; all other behaviour identical.

Verification
REQ-027 Reset: rst=1 two cycles mid-RUN -> in_ready=1, out_valid=0, result=0 next cycle, no stale output.
REQ-028 ADD: src1=0x00000005, src2=0x00000003, control=0010 -> out_valid on cycle 33 after accept, result=0x00000008.
REQ-029 SUB overflow: src1=0x80000000, src2=0x00000001, control=0110 -> result=0x7FFFFFFF; with ALU_SERIAL_FLAGS_EN overflow=1, cout=1, zero=0.
REQ-030 SLT: src1=0xFFFFFFFF (-1), src2=0x00000001, control=0111 -> result=0x00000001; swapped operands -> 0x00000000.
REQ-031 Handshake: hold out_ready=0 5 cycles in DONE with in_valid=1 -> result stable, in_ready=0, no accept; out_ready=1 -> IDLE next cycle.
REQ-032 NOR: src1=0x0F0F0F0F, src2=0x00FF00FF, control=1100 -> result=0xF000F000.
